dt_scheduler: RTL and testbench

DT_SCHEDULER -- requirements
Module: dt_scheduler

---
 rtl/dt_scheduler_if.sv | 25 ++
 rtl/dt_scheduler.sv | 143 ++++++++++++++
 tb/tb_dt_scheduler.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dt_scheduler_if.sv
// Handshake bundle between dt_scheduler and the external dt multiplier.
// The scheduler is the master: it arms the multiplier and supplies the cycle count.
interface dt_scheduler_if #(
  parameter int CYCLE_COUNT_WID = 18,
  parameter int DT_WID          = 33
);
  logic                       mul_arm;
  logic [CYCLE_COUNT_WID-1:0] mul_cycles;
  logic                       mul_finished;
  logic [DT_WID-1:0]          mul_dt;

  modport master (
    output mul_arm,
    output mul_cycles,
    input  mul_finished,
    input  mul_dt
  );

  modport slave (
    input  mul_arm,
    input  mul_cycles,
    output mul_finished,
    output mul_dt
  );
endinterface

// File: rtl/dt_scheduler.sv
// Measures cycles between control-loop samples, hands the count to an external
// multiplier to form dt, and holds the result until the consumer acknowledges it.
module dt_scheduler #(
  parameter int CYCLE_COUNT_WID = 18,
  parameter int DT_WID          = 33,
  parameter int TIMEOUT         = 1024
) (
  input  logic              clk,
  input  logic              rst_L,
  input  logic              sample,
  dt_scheduler_if.master    mul,
  output logic [DT_WID-1:0] dt,
  output logic              dt_valid,
  input  logic              dt_ack,
  output logic              overrun,
  output logic              timeout_err
);

  localparam int TMR_W = $clog2(TIMEOUT + 1);
  // Leading zero kept on the count because the multiplier treats it as signed.
  localparam logic [CYCLE_COUNT_WID-1:0] CNT_MAX  = {1'b0, {(CYCLE_COUNT_WID-1){1'b1}}};
  localparam logic [CYCLE_COUNT_WID-1:0] CNT_ONE  = CYCLE_COUNT_WID'(1);
  localparam logic [TMR_W-1:0]           TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [TMR_W-1:0]           TMR_ONE  = TMR_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    VALID = 2'd2,
    CLEAR = 2'd3
  } state_t;

  state_t                     state, state_nxt;
  logic [CYCLE_COUNT_WID-1:0] counter;
  logic [TMR_W-1:0]           tmr;
  logic                       accept;
  logic                       done;
  logic                       tmo;
  logic                       ack_take;
  logic                       ovr_set;

  function automatic logic [CYCLE_COUNT_WID-1:0] sat_inc(
    input logic [CYCLE_COUNT_WID-1:0] v
  );
    return (v >= CNT_MAX) ? CNT_MAX : v + CNT_ONE;
  endfunction

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    done      = 1'b0;
    tmo       = 1'b0;
    ack_take  = 1'b0;
    ovr_set   = 1'b0;
    case (state)
      IDLE: begin
        if (sample) begin
          accept    = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        ovr_set = sample;
        if (mul.mul_finished) begin
          done      = 1'b1;
          state_nxt = VALID;
        end else if (tmr == TMR_LAST) begin
          tmo       = 1'b1;
          state_nxt = CLEAR;
        end
      end
      VALID: begin
        ovr_set = sample;
        if (dt_ack) begin
          ack_take  = 1'b1;
          state_nxt = CLEAR;
        end
      end
      CLEAR: begin
        // Hold here until the multiplier has seen the disarm and dropped finished.
        ovr_set = sample;
        if (!mul.mul_finished) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      counter        <= '0;
      tmr            <= '0;
      mul.mul_arm    <= 1'b0;
      mul.mul_cycles <= '0;
      dt             <= '0;
      dt_valid       <= 1'b0;
      overrun        <= 1'b0;
      timeout_err    <= 1'b0;
    end else begin
      counter <= accept ? CNT_ONE : sat_inc(counter);

      if (accept) begin
        tmr <= '0;
      end else if (state == WAIT) begin
        tmr <= tmr + TMR_ONE;
      end

      if (accept) begin
        mul.mul_arm    <= 1'b1;
        mul.mul_cycles <= counter;
      end else if (done || tmo) begin
        mul.mul_arm <= 1'b0;
      end

      if (done) begin
        dt <= mul.mul_dt;
      end

      if (done) begin
        dt_valid <= 1'b1;
      end else if (ack_take) begin
        dt_valid <= 1'b0;
      end

      if (ovr_set) begin
        overrun <= 1'b1;
      end
      if (tmo) begin
        timeout_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dt_scheduler.sv
// Directed bench for dt_scheduler with a behavioural multiplier (dt = 5 * cycles,
// finished 20 cycles after arm, optional never-finish and hold-after-disarm modes).
module tb_dt_scheduler;

  localparam int CW      = 12;
  localparam int DW      = 33;
  localparam int TMO     = 100;
  localparam int MDL_LAT = 20;
  localparam logic [DW-1:0] K = 33'd5;

  logic clk = 1'b0;
  logic rst_L = 1'b0;
  logic sample = 1'b0;
  logic dt_ack = 1'b0;
  logic [DW-1:0] dt;
  logic dt_valid;
  logic overrun;
  logic timeout_err;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;

  bit mdl_never = 1'b0;
  int mdl_hold  = 0;
  logic          fin;
  logic [DW-1:0] mdl_dt;
  int            mcnt;
  int            hcnt;

  dt_scheduler_if #(.CYCLE_COUNT_WID(CW), .DT_WID(DW)) mif ();

  dt_scheduler #(
    .CYCLE_COUNT_WID(CW),
    .DT_WID(DW),
    .TIMEOUT(TMO)
  ) dut (
    .clk(clk),
    .rst_L(rst_L),
    .sample(sample),
    .mul(mif),
    .dt(dt),
    .dt_valid(dt_valid),
    .dt_ack(dt_ack),
    .overrun(overrun),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Multiplier model: raises finished MDL_LAT cycles after arm, keeps it high
  // for mdl_hold extra cycles after disarm.
  always @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      fin    <= 1'b0;
      mdl_dt <= '0;
      mcnt   <= 0;
      hcnt   <= 0;
    end else if (mif.mul_arm) begin
      hcnt <= 0;
      mcnt <= mcnt + 1;
      if (!mdl_never && mcnt == MDL_LAT - 1) begin
        fin    <= 1'b1;
        mdl_dt <= K * DW'(mif.mul_cycles);
      end
    end else begin
      mcnt <= 0;
      if (fin) begin
        if (hcnt >= mdl_hold) fin <= 1'b0;
        else                  hcnt <= hcnt + 1;
      end
    end
  end

  assign mif.mul_finished = fin;
  assign mif.mul_dt       = mdl_dt;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic pulse_sample();
    sample = 1'b1;
    tick();
    sample = 1'b0;
  endtask

  task automatic pulse_ack();
    dt_ack = 1'b1;
    tick();
    dt_ack = 1'b0;
  endtask

  task automatic wait_valid(input string tag, output int n);
    n = 0;
    while (!dt_valid && n < 200) begin
      tick();
      n++;
    end
    chk(tag, 64'(dt_valid), 64'(1));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int s0, s1, sf;

    // Reset state
    tick();
    tick();
    chk("rst_arm",    64'(mif.mul_arm),    64'(0));
    chk("rst_cycles", 64'(mif.mul_cycles), 64'(0));
    chk("rst_dt",     64'(dt),             64'(0));
    chk("rst_valid",  64'(dt_valid),       64'(0));
    chk("rst_ovr",    64'(overrun),        64'(0));
    chk("rst_tmo",    64'(timeout_err),    64'(0));

    // First transaction: counter starts right after reset release
    rst_L = 1'b1;
    repeat (3) tick();
    pulse_sample();
    s0 = cyc;
    chk("t1_arm",    64'(mif.mul_arm),    64'(1));
    chk("t1_cycles", 64'(mif.mul_cycles), 64'(3));
    wait_valid("t1_valid", n);
    chk("t1_latency", 64'(n),           64'(MDL_LAT + 1));
    chk("t1_dt",      64'(dt),          64'(15));
    chk("t1_disarm",  64'(mif.mul_arm), 64'(0));
    repeat (3) tick();
    chk("t1_hold_valid", 64'(dt_valid), 64'(1));
    chk("t1_hold_dt",    64'(dt),       64'(15));
    pulse_ack();
    chk("t1_ack", 64'(dt_valid), 64'(0));

    // Second sample 1000 cycles after the first
    while (cyc < s0 + 999) tick();
    pulse_sample();
    s1 = cyc;
    chk("t2_cycles", 64'(mif.mul_cycles), 64'(1000));
    chk("t2_arm",    64'(mif.mul_arm),    64'(1));
    repeat (5) tick();
    pulse_sample();
    chk("t2_ovr",        64'(overrun),        64'(1));
    chk("t2_ovr_arm",    64'(mif.mul_arm),    64'(1));
    chk("t2_ovr_cycles", 64'(mif.mul_cycles), 64'(1000));
    wait_valid("t2_valid", n);
    chk("t2_dt", 64'(dt), 64'(5000));
    pulse_ack();
    repeat (3) tick();
    // Ack while idle must not disturb anything
    pulse_ack();
    chk("idle_ack_valid", 64'(dt_valid), 64'(0));
    chk("idle_ack_dt",    64'(dt),       64'(5000));
    // Overrun sample did not restart the count
    while (cyc < s1 + 299) tick();
    pulse_sample();
    chk("t3_cycles", 64'(mif.mul_cycles), 64'(300));
    wait_valid("t3_valid", n);
    chk("t3_dt",         64'(dt),      64'(1500));
    chk("t3_ovr_sticky", 64'(overrun), 64'(1));
    pulse_ack();
    repeat (2) tick();

    // Reset in the middle of WAIT
    pulse_sample();
    repeat (4) tick();
    chk("c_pre_arm", 64'(mif.mul_arm), 64'(1));
    rst_L = 1'b0;
    #1;
    chk("c_rst_arm",    64'(mif.mul_arm),    64'(0));
    chk("c_rst_cycles", 64'(mif.mul_cycles), 64'(0));
    chk("c_rst_dt",     64'(dt),             64'(0));
    chk("c_rst_ovr",    64'(overrun),        64'(0));
    chk("c_rst_valid",  64'(dt_valid),       64'(0));
    tick();
    tick();
    rst_L = 1'b1;
    repeat (10) tick();
    pulse_sample();
    chk("c_cycles", 64'(mif.mul_cycles), 64'(10));
    chk("c_arm",    64'(mif.mul_arm),    64'(1));
    wait_valid("c_valid", n);
    chk("c_latency", 64'(n),  64'(MDL_LAT + 1));
    chk("c_dt",      64'(dt), 64'(50));
    pulse_ack();

    // Counter saturation with leading zero
    repeat (2100) tick();
    pulse_sample();
    chk("sat_cycles", 64'(mif.mul_cycles),       64'(2047));
    chk("sat_msb",    64'(mif.mul_cycles[CW-1]), 64'(0));
    wait_valid("sat_valid", n);
    chk("sat_dt", 64'(dt), 64'(10235));
    pulse_ack();
    repeat (3) tick();

    // Multiplier never finishes
    mdl_never = 1'b1;
    pulse_sample();
    repeat (TMO - 1) tick();
    chk("tmo_early",     64'(timeout_err), 64'(0));
    chk("tmo_early_arm", 64'(mif.mul_arm), 64'(1));
    tick();
    chk("tmo_err",   64'(timeout_err), 64'(1));
    chk("tmo_arm",   64'(mif.mul_arm), 64'(0));
    chk("tmo_valid", 64'(dt_valid),    64'(0));
    chk("tmo_dt",    64'(dt),          64'(10235));
    chk("tmo_ovr",   64'(overrun),     64'(0));
    repeat (3) tick();
    mdl_never = 1'b0;

    // Finished held after disarm: block waits in CLEAR
    mdl_hold = 5;
    pulse_sample();
    sf = cyc;
    wait_valid("h_valid", n);
    pulse_ack();
    chk("h_ack", 64'(dt_valid), 64'(0));
    pulse_sample();
    chk("h_ovr", 64'(overrun),     64'(1));
    chk("h_arm", 64'(mif.mul_arm), 64'(0));
    n = 0;
    while (mif.mul_finished && n < 20) begin
      tick();
      n++;
    end
    chk("h_fin_drop", 64'(mif.mul_finished), 64'(0));
    tick();
    pulse_sample();
    chk("h_rearm",  64'(mif.mul_arm),    64'(1));
    chk("h_cycles", 64'(mif.mul_cycles), 64'(cyc - sf));
    wait_valid("h_valid2", n);
    pulse_ack();
    mdl_hold = 0;
    repeat (3) tick();

    // Sample and ack in the same VALID cycle
    rst_L = 1'b0;
    tick();
    tick();
    rst_L = 1'b1;
    tick();
    pulse_sample();
    chk("g_cycles", 64'(mif.mul_cycles), 64'(1));
    wait_valid("g_valid", n);
    chk("g_dt", 64'(dt), 64'(5));
    dt_ack = 1'b1;
    sample = 1'b1;
    tick();
    dt_ack = 1'b0;
    sample = 1'b0;
    chk("g_ack",     64'(dt_valid),    64'(0));
    chk("g_ovr",     64'(overrun),     64'(1));
    chk("g_no_arm",  64'(mif.mul_arm), 64'(0));
    repeat (2) tick();
    pulse_sample();
    chk("g_rearm", 64'(mif.mul_arm), 64'(1));
    wait_valid("g_valid2", n);
    pulse_ack();
    repeat (2) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
